wb_sequencer: RTL and testbench

WB_SEQUENCER -- requirements
Module: wb_sequencer

---
 rtl/wb_sequencer_if.sv | 20 ++
 rtl/wb_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_wb_sequencer.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sequencer_if.sv
// Data-memory bus between the writeback sequencer (master) and the data memory (slave).
// A level request is held until the memory acknowledges it; load data is valid with the ack.
interface wb_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/wb_sequencer.sv
// Memory-access / writeback sequencer: IDLE -> (MEM) -> WB for loads, stores and ALU ops.
// Optional ack timeout is compiled in with `define WB_SEQ_TIMEOUT_EN.
module wb_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  RegWrite_in,
  input  logic [31:0]           ALUResult,
  input  logic [31:0]           StoreData,
  input  logic [4:0]            WriteReg,
  wb_sequencer_if.master        memBus,
  output logic                  stall,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic [31:0]           WriteData,
  output logic [4:0]            WriteRegOut,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2
  } seqState_t;

  seqState_t   state,       stateNext;
  logic        memReq,      memReqNext;
  logic        memWe,       memWeNext;
  logic [31:0] memAddr,     memAddrNext;
  logic [31:0] memWdata,    memWdataNext;
  logic        memtoReg,    memtoRegNext;
  logic        regWrite,    regWriteNext;
  logic [31:0] writeData,   writeDataNext;
  logic [4:0]  writeRegOut, writeRegOutNext;
  logic [4:0]  capReg,      capRegNext;
  logic        timeoutHit;

  // Destination of an outstanding load is parked in capReg so WriteRegOut
  // only moves when a writeback actually happens.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    stateNext       = state;
    memReqNext      = memReq;
    memWeNext       = memWe;
    memAddrNext     = memAddr;
    memWdataNext    = memWdata;
    memtoRegNext    = memtoReg;
    regWriteNext    = 1'b0;
    writeDataNext   = writeData;
    writeRegOutNext = writeRegOut;
    capRegNext      = capReg;

    unique case (state)
      IDLE: begin
        if (instr_valid) begin
          if (MemRead) begin
            memReqNext  = 1'b1;
            memWeNext   = 1'b0;
            memAddrNext = ALUResult;
            capRegNext  = WriteReg;
            stateNext   = MEM;
          end else if (MemWrite) begin
            memReqNext   = 1'b1;
            memWeNext    = 1'b1;
            memAddrNext  = ALUResult;
            memWdataNext = StoreData;
            stateNext    = MEM;
          end else if (RegWrite_in) begin
            memtoRegNext    = 1'b0;
            writeDataNext   = ALUResult;
            writeRegOutNext = WriteReg;
            regWriteNext    = (WriteReg != 5'd0);
            stateNext       = WB;
          end
        end
      end

      MEM: begin
        if (memBus.mem_ack) begin
          memReqNext = 1'b0;
          if (!memWe) begin
            memtoRegNext    = 1'b1;
            writeDataNext   = memBus.mem_rdata;
            writeRegOutNext = capReg;
            regWriteNext    = (capReg != 5'd0);
            stateNext       = WB;
          end else begin
            stateNext = IDLE;
          end
        end else if (timeoutHit) begin
          memReqNext = 1'b0;
          stateNext  = IDLE;
        end
      end

      WB: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext  = IDLE;
        memReqNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state       <= IDLE;
      memReq      <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= 32'd0;
      memWdata    <= 32'd0;
      memtoReg    <= 1'b0;
      regWrite    <= 1'b0;
      writeData   <= 32'd0;
      writeRegOut <= 5'd0;
      capReg      <= 5'd0;
    end else begin
      state       <= stateNext;
      memReq      <= memReqNext;
      memWe       <= memWeNext;
      memAddr     <= memAddrNext;
      memWdata    <= memWdataNext;
      memtoReg    <= memtoRegNext;
      regWrite    <= regWriteNext;
      writeData   <= writeDataNext;
      writeRegOut <= writeRegOutNext;
      capReg      <= capRegNext;
    end
  end

`ifdef WB_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] waitCnt;
  logic       timeoutErr;

  // waitCnt holds the number of ack-less MEM cycles already spent, so the
  // abort fires during the TIMEOUT_CYCLES-th one; an ack that cycle wins.
  assign timeoutHit = (state == MEM) && !memBus.mem_ack && (waitCnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waitCnt    <= 8'd0;
      timeoutErr <= 1'b0;
    end else begin
      if ((state == MEM) && !memBus.mem_ack) begin
        waitCnt <= waitCnt + 8'd1;
      end else begin
        waitCnt <= 8'd0;
      end
      if (timeoutHit) begin
        timeoutErr <= 1'b1;
      end
    end
  end

  assign timeout_err = timeoutErr;
`else
  // Never true for the legal parameter range, so MEM waits for ack forever.
  assign timeoutHit  = (TIMEOUT_CYCLES == 0);
  assign timeout_err = 1'b0;
`endif

  assign stall            = (state != IDLE);
  assign memBus.mem_req   = memReq;
  assign memBus.mem_we    = memWe;
  assign memBus.mem_addr  = memAddr;
  assign memBus.mem_wdata = memWdata;
  assign MemtoReg         = memtoReg;
  assign RegWrite         = regWrite;
  assign WriteData        = writeData;
  assign WriteRegOut      = writeRegOut;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed testbench for wb_sequencer: ALU, load, store, priority, $zero, ignore rules,
// mid-access reset and either the ack timeout or the unbounded wait, depending on the build.
module tb_wb_sequencer;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite_in;
  logic [31:0] ALUResult;
  logic [31:0] StoreData;
  logic [4:0]  WriteReg;
  logic        stall;
  logic        MemtoReg;
  logic        RegWrite;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegOut;
  logic        timeout_err;
  logic [106:0] allOuts;

  int vectors = 0;
  int miscompares = 0;

  wb_sequencer_if memBus();

  wb_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .RegWrite_in (RegWrite_in),
    .ALUResult   (ALUResult),
    .StoreData   (StoreData),
    .WriteReg    (WriteReg),
    .memBus      (memBus),
    .stall       (stall),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .WriteData   (WriteData),
    .WriteRegOut (WriteRegOut),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  assign allOuts = {memBus.mem_req, memBus.mem_we, memBus.mem_addr, memBus.mem_wdata,
                    MemtoReg, RegWrite, WriteData, WriteRegOut, timeout_err, stall};

  // Inputs change and outputs are sampled on the falling edge, clear of the active edge.
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clearInputs;
    instr_valid = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite_in = 1'b0;
    ALUResult   = 32'd0;
    StoreData   = 32'd0;
    WriteReg    = 5'd0;
    memBus.mem_ack   = 1'b0;
    memBus.mem_rdata = 32'd0;
  endtask

  // Presents one instruction for one edge, then scrambles the decoder inputs so that
  // later checks prove the values were captured. Returns in the first cycle after accept.
  task automatic issue(input logic rd, input logic wr, input logic rw,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dst);
    instr_valid = 1'b1;
    MemRead     = rd;
    MemWrite    = wr;
    RegWrite_in = rw;
    ALUResult   = alu;
    StoreData   = sd;
    WriteReg    = dst;
    tick();
    instr_valid = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite_in = 1'b0;
    ALUResult   = 32'hBAD0_BAD0;
    StoreData   = 32'hBAD1_BAD1;
    WriteReg    = 5'd31;
  endtask

  task automatic test_reset;
    clearInputs();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if (allOuts !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want all zero", allOuts);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_stall: got %b want 0", stall);
    end
  endtask

  task automatic test_alu_op;
    issue(1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5, 32'd0, 5'd5);
    vectors++;
    if ({RegWrite, MemtoReg, stall, memBus.mem_req} !== 4'b1010) begin
      miscompares++;
      $display("FAIL alu_ctrl {RegWrite,MemtoReg,stall,mem_req}: got %b want 1010",
               {RegWrite, MemtoReg, stall, memBus.mem_req});
    end
    vectors++;
    if (WriteData !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL alu_wdata: got %h want a5a5a5a5", WriteData);
    end
    vectors++;
    if (WriteRegOut !== 5'd5) begin
      miscompares++;
      $display("FAIL alu_wreg: got %0d want 5", WriteRegOut);
    end
    tick();
    vectors++;
    if ({RegWrite, stall} !== 2'b00 || WriteData !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL alu_after {RegWrite,stall}=%b want 00, WriteData=%h want a5a5a5a5",
               {RegWrite, stall}, WriteData);
    end
  endtask

  task automatic test_load;
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'd0, 5'd7);
    vectors++;
    if (memBus.mem_we !== 1'b0 || memBus.mem_addr !== 32'h0000_0040) begin
      miscompares++;
      $display("FAIL load_bus: mem_we=%b want 0, mem_addr=%h want 00000040",
               memBus.mem_we, memBus.mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({memBus.mem_req, stall, RegWrite} !== 3'b110) begin
        miscompares++;
        $display("FAIL load_wait%0d {mem_req,stall,RegWrite}: got %b want 110",
                 i, {memBus.mem_req, stall, RegWrite});
      end
      if (i == 2) begin
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    memBus.mem_ack   = 1'b0;
    memBus.mem_rdata = 32'h0BAD_0BAD;
    vectors++;
    if ({memBus.mem_req, RegWrite, MemtoReg} !== 3'b011) begin
      miscompares++;
      $display("FAIL load_wb {mem_req,RegWrite,MemtoReg}: got %b want 011",
               {memBus.mem_req, RegWrite, MemtoReg});
    end
    vectors++;
    if (WriteData !== 32'hDEAD_BEEF || WriteRegOut !== 5'd7) begin
      miscompares++;
      $display("FAIL load_data: WriteData=%h want deadbeef, WriteRegOut=%0d want 7",
               WriteData, WriteRegOut);
    end
    tick();
    vectors++;
    if ({RegWrite, stall, MemtoReg} !== 3'b001 || WriteData !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL load_hold {RegWrite,stall,MemtoReg}=%b want 001, WriteData=%h want deadbeef",
               {RegWrite, stall, MemtoReg}, WriteData);
    end
  endtask

  task automatic test_store;
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, 5'd9);
    vectors++;
    if ({memBus.mem_req, memBus.mem_we, RegWrite} !== 3'b110) begin
      miscompares++;
      $display("FAIL store_ctrl {mem_req,mem_we,RegWrite}: got %b want 110",
               {memBus.mem_req, memBus.mem_we, RegWrite});
    end
    vectors++;
    if (memBus.mem_addr !== 32'h0000_0010 || memBus.mem_wdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL store_bus: mem_addr=%h want 00000010, mem_wdata=%h want 12345678",
               memBus.mem_addr, memBus.mem_wdata);
    end
    memBus.mem_ack = 1'b1;
    tick();
    memBus.mem_ack = 1'b0;
    vectors++;
    if ({memBus.mem_req, stall, RegWrite} !== 3'b000) begin
      miscompares++;
      $display("FAIL store_done {mem_req,stall,RegWrite}: got %b want 000",
               {memBus.mem_req, stall, RegWrite});
    end
    vectors++;
    if (MemtoReg !== 1'b1 || WriteData !== 32'hDEAD_BEEF || WriteRegOut !== 5'd7) begin
      miscompares++;
      $display("FAIL store_no_wb: MemtoReg=%b WriteData=%h WriteRegOut=%0d want 1 deadbeef 7",
               MemtoReg, WriteData, WriteRegOut);
    end
    tick();
    vectors++;
    if (RegWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL store_late_pulse: got %b want 0", RegWrite);
    end
  endtask

  task automatic test_priority;
    issue(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_5555, 5'd3);
    vectors++;
    if ({memBus.mem_req, memBus.mem_we} !== 2'b10 || memBus.mem_addr !== 32'h0000_0020) begin
      miscompares++;
      $display("FAIL prio_bus {mem_req,mem_we}=%b want 10, mem_addr=%h want 00000020",
               {memBus.mem_req, memBus.mem_we}, memBus.mem_addr);
    end
    memBus.mem_ack   = 1'b1;
    memBus.mem_rdata = 32'hCAFE_F00D;
    tick();
    memBus.mem_ack = 1'b0;
    vectors++;
    if (RegWrite !== 1'b1 || WriteData !== 32'hCAFE_F00D || WriteRegOut !== 5'd3) begin
      miscompares++;
      $display("FAIL prio_wb: RegWrite=%b WriteData=%h WriteRegOut=%0d want 1 cafef00d 3",
               RegWrite, WriteData, WriteRegOut);
    end
    tick();
  endtask

  task automatic test_no_op;
    issue(1'b0, 1'b0, 1'b0, 32'h0000_0012, 32'd0, 5'd4);
    vectors++;
    if ({stall, RegWrite, memBus.mem_req} !== 3'b000 ||
        WriteData !== 32'hCAFE_F00D || WriteRegOut !== 5'd3) begin
      miscompares++;
      $display("FAIL no_op: {stall,RegWrite,mem_req}=%b want 000, WriteData=%h want cafef00d, WriteRegOut=%0d want 3",
               {stall, RegWrite, memBus.mem_req}, WriteData, WriteRegOut);
    end
  endtask

  task automatic test_zero_reg;
    issue(1'b0, 1'b0, 1'b1, 32'h0000_0077, 32'd0, 5'd0);
    vectors++;
    if ({stall, RegWrite} !== 2'b10) begin
      miscompares++;
      $display("FAIL zero_reg_wb {stall,RegWrite}: got %b want 10", {stall, RegWrite});
    end
    tick();
    vectors++;
    if ({stall, RegWrite} !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_reg_after {stall,RegWrite}: got %b want 00", {stall, RegWrite});
    end
  endtask

  task automatic test_ignore;
    memBus.mem_ack = 1'b1;
    tick();
    memBus.mem_ack = 1'b0;
    vectors++;
    if ({memBus.mem_req, stall, RegWrite} !== 3'b000) begin
      miscompares++;
      $display("FAIL ignore_idle_ack {mem_req,stall,RegWrite}: got %b want 000",
               {memBus.mem_req, stall, RegWrite});
    end
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'd0, 5'd12);
    instr_valid = 1'b1;
    RegWrite_in = 1'b1;
    ALUResult   = 32'h1111_1111;
    WriteReg    = 5'd13;
    tick();
    vectors++;
    if ({memBus.mem_req, RegWrite} !== 2'b10 || memBus.mem_addr !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL ignore_mem_instr {mem_req,RegWrite}=%b want 10, mem_addr=%h want 00000080",
               {memBus.mem_req, RegWrite}, memBus.mem_addr);
    end
    memBus.mem_ack   = 1'b1;
    memBus.mem_rdata = 32'h0F0F_0F0F;
    tick();
    vectors++;
    if (RegWrite !== 1'b1 || WriteData !== 32'h0F0F_0F0F || WriteRegOut !== 5'd12) begin
      miscompares++;
      $display("FAIL ignore_wb: RegWrite=%b WriteData=%h WriteRegOut=%0d want 1 0f0f0f0f 12",
               RegWrite, WriteData, WriteRegOut);
    end
    tick();
    clearInputs();
    vectors++;
    if ({memBus.mem_req, stall, RegWrite} !== 3'b000) begin
      miscompares++;
      $display("FAIL ignore_wb_instr {mem_req,stall,RegWrite}: got %b want 000",
               {memBus.mem_req, stall, RegWrite});
    end
  endtask

  task automatic test_reset_mid_mem;
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'd0, 5'd6);
    tick();
    vectors++;
    if (memBus.mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mem_req: got %b want 1", memBus.mem_req);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if (allOuts !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_mem_outputs: got %h want all zero", allOuts);
    end
    rst_n = 1'b1;
    memBus.mem_ack   = 1'b1;
    memBus.mem_rdata = 32'h9999_9999;
    tick();
    memBus.mem_ack = 1'b0;
    tick();
    vectors++;
    if ({memBus.mem_req, stall, RegWrite} !== 3'b000 || WriteData !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_late_ack {mem_req,stall,RegWrite}=%b want 000, WriteData=%h want 0",
               {memBus.mem_req, stall, RegWrite}, WriteData);
    end
  endtask

`ifdef WB_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int  highCycles;
    logic sawWrite;
    highCycles = 0;
    sawWrite   = 1'b0;
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'd0, 5'd8);
    for (int i = 0; i < 40 && memBus.mem_req === 1'b1; i++) begin
      highCycles++;
      if (RegWrite !== 1'b0) sawWrite = 1'b1;
      tick();
    end
    vectors++;
    if (highCycles != int'(TIMEOUT)) begin
      miscompares++;
      $display("FAIL timeout_req_cycles: got %0d want %0d", highCycles, TIMEOUT);
    end
    vectors++;
    if ({timeout_err, stall, RegWrite, sawWrite} !== 4'b1000) begin
      miscompares++;
      $display("FAIL timeout_abort {timeout_err,stall,RegWrite,sawWrite}: got %b want 1000",
               {timeout_err, stall, RegWrite, sawWrite});
    end
    issue(1'b0, 1'b0, 1'b1, 32'h1357_9BDF, 32'd0, 5'd9);
    vectors++;
    if (RegWrite !== 1'b1 || WriteData !== 32'h1357_9BDF || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_then_alu: RegWrite=%b WriteData=%h timeout_err=%b want 1 13579bdf 1",
               RegWrite, WriteData, timeout_err);
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err_clear: got %b want 0", timeout_err);
    end
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'd0, 5'd10);
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      if (i == int'(TIMEOUT) - 1) begin
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = 32'h2468_ACE0;
      end
      tick();
    end
    memBus.mem_ack = 1'b0;
    vectors++;
    if (RegWrite !== 1'b1 || WriteData !== 32'h2468_ACE0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_ack_wins: RegWrite=%b WriteData=%h timeout_err=%b want 1 2468ace0 0",
               RegWrite, WriteData, timeout_err);
    end
    tick();
  endtask
`else
  task automatic test_long_wait;
    int highCycles;
    highCycles = 0;
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'd0, 5'd8);
    for (int i = 0; i < 40; i++) begin
      if (memBus.mem_req === 1'b1 && timeout_err === 1'b0) highCycles++;
      tick();
    end
    vectors++;
    if (highCycles != 40) begin
      miscompares++;
      $display("FAIL long_wait_req_cycles: got %0d want 40", highCycles);
    end
    memBus.mem_ack   = 1'b1;
    memBus.mem_rdata = 32'h2468_ACE0;
    tick();
    memBus.mem_ack = 1'b0;
    vectors++;
    if (RegWrite !== 1'b1 || WriteData !== 32'h2468_ACE0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL long_wait_wb: RegWrite=%b WriteData=%h timeout_err=%b want 1 2468ace0 0",
               RegWrite, WriteData, timeout_err);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_priority();
    test_no_op();
    test_zero_reg();
    test_ignore();
    test_reset_mid_mem();
`ifdef WB_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
